seq_divider_param: RTL and testbench

- Parametrised sequential radix-2 restoring divider with a start/done handshake and selectable signed/unsigned mode.
- Adds divide-by-zero and signed-overflow flags.
- Sits behind the arithmetic unit as a multi-cycle functional unit.
- Internally split into a controller FSM and a datapath; exposes a single clean handshake interface.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 23 ++
 rtl/seq_divider_param.sv | 126 ++++++++++++
 tb/tb_seq_divider_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// bench-facing latency constants and the counter-width helper.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int LAT_DBZ = 2;

  function automatic int lat_norm(input int nbit);
    return nbit + 3;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step #(
  parameter int NBIT = 8
) (
  input  logic [NBIT-1:0] rem,
  input  logic            dvd_msb,
  input  logic [NBIT-1:0] divisor,
  output logic [NBIT-1:0] rem_next,
  output logic            q_bit
);

  logic [NBIT:0] rem_sh;
  logic [NBIT:0] trial;

  assign rem_sh = {rem, dvd_msb};
  assign trial  = rem_sh - {1'b0, divisor};
  // With rem's MSB set the shifted value exceeds any divisor, so the
  // subtraction always succeeds even though trial's top bit may read as 1.
  assign q_bit    = rem[NBIT-1] | ~trial[NBIT];
  assign rem_next = q_bit ? trial[NBIT-1:0] : rem_sh[NBIT-1:0];

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake,
// divide-by-zero and signed-overflow flags. Outputs are registered.
module seq_divider_param
  import div_pkg::*;
#(
  parameter int NBIT      = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [NBIT-1:0] A,
  input  logic [NBIT-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [NBIT-1:0] Q,
  output logic [NBIT-1:0] R,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int            CW       = clog2(NBIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBIT - 1);

  state_t          state_q, state_d;
  logic [NBIT-1:0] a_q, b_q, dvd_q, dvs_q, rem_q;
  logic            sgn_q, qneg_q, rneg_q;
  logic [CW-1:0]   cnt_q;

  logic [NBIT-1:0] rem_nx;
  logic            q_bit;
  logic            a_neg, b_neg, b_zero, ovf;
  logic [NBIT-1:0] a_mag, b_mag, q_fix, r_fix;

  div_step #(.NBIT(NBIT)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[NBIT-1]),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  assign a_neg  = sgn_q & a_q[NBIT-1];
  assign b_neg  = sgn_q & b_q[NBIT-1];
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;
  assign b_zero = (b_q == '0);
  assign q_fix  = qneg_q ? -dvd_q : dvd_q;
  assign r_fix  = rneg_q ? -rem_q : rem_q;
  // MIN / -1 needs no special datapath: |MIN| wraps back to MIN in NBIT bits.
  assign ovf    = sgn_q && (a_q == {1'b1, {(NBIT-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = b_zero ? DONE : ITER;
      ITER:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= state_q inside {LOAD, ITER, FIX};
      done    <= (state_q == DONE);
      unique case (state_q)
        IDLE: if (start) begin
          a_q         <= A;
          b_q         <= B;
          sgn_q       <= SIGNED_EN && signed_mode;
          Q           <= '0;
          R           <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
        LOAD: begin
          dvd_q  <= a_mag;
          dvs_q  <= b_mag;
          rem_q  <= '0;
          cnt_q  <= CNT_LAST;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          if (b_zero) begin
            Q           <= '1;
            R           <= a_q;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          dvd_q <= {dvd_q[NBIT-2:0], q_bit};
          rem_q <= rem_nx;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          Q        <= q_fix;
          R        <= r_fix;
          overflow <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_param.sv
// Scoreboarded bench for seq_divider_param at NBIT=8 (directed), 4 (exhaustive)
// and 16 (random), with latency, busy-width, hold-start and reset checks.
module tb_seq_divider_param;
  import div_pkg::*;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  logic        start8, sm8, busy8, done8, dbz8, ovf8;
  logic [7:0]  a8, b8, q8, r8;
  logic        start4, sm4, busy4, done4, dbz4, ovf4;
  logic [3:0]  a4, b4, q4, r4;
  logic        start16, sm16, busy16, done16, dbz16, ovf16;
  logic [15:0] a16, b16, q16, r16;

  exp_t sb8[$], sb4[$], sb16[$];
  exp_t e8, e4, e16;

  seq_divider_param #(.NBIT(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .reset(rst), .start(start8), .signed_mode(sm8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_by_zero(dbz8), .overflow(ovf8));
  seq_divider_param #(.NBIT(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk(clk), .reset(rst), .start(start4), .signed_mode(sm4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Q(q4), .R(r4), .div_by_zero(dbz4), .overflow(ovf4));
  seq_divider_param #(.NBIT(16), .SIGNED_EN(1'b1)) u_dut16 (
    .clk(clk), .reset(rst), .start(start16), .signed_mode(sm16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Q(q16), .R(r16), .div_by_zero(dbz16), .overflow(ovf16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference built on native division: truncating quotient, dividend-signed remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int n, input bit sg);
    longint mask, sa, sb, qq, rr;
    exp_t   e;
    e    = '0;
    mask = (longint'(1) << n) - 1;
    if (b == 0) begin
      e.q   = 32'(mask);
      e.r   = a;
      e.dbz = 1'b1;
      return e;
    end
    if (sg) begin
      sa    = a[n-1] ? longint'(a) - (longint'(1) << n) : longint'(a);
      sb    = b[n-1] ? longint'(b) - (longint'(1) << n) : longint'(b);
      qq    = sa / sb;
      rr    = sa % sb;
      e.ovf = (sa == -(longint'(1) << (n - 1))) && (sb == -1);
    end else begin
      qq = longint'(a) / longint'(b);
      rr = longint'(a) % longint'(b);
    end
    e.q = 32'(qq & mask);
    e.r = 32'(rr & mask);
    return e;
  endfunction

  always @(negedge clk) if (done8) begin
    if (sb8.size() == 0) chk("dut8_spurious_done", 1, 0);
    else begin
      e8 = sb8.pop_front();
      chk("dut8_result", {32'(q8), 32'(r8), dbz8, ovf8}, e8);
    end
  end

  always @(negedge clk) if (done4) begin
    if (sb4.size() == 0) chk("dut4_spurious_done", 1, 0);
    else begin
      e4 = sb4.pop_front();
      chk("dut4_result", {32'(q4), 32'(r4), dbz4, ovf4}, e4);
    end
  end

  always @(negedge clk) if (done16) begin
    if (sb16.size() == 0) chk("dut16_spurious_done", 1, 0);
    else begin
      e16 = sb16.pop_front();
      chk("dut16_result", {32'(q16), 32'(r16), dbz16, ovf16}, e16);
    end
  end

  // Directed NBIT=8 op with hand-computed results; checks latency and busy width.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sg,
                     input logic [7:0] eq, input logic [7:0] er,
                     input bit ez, input bit eo, input int exp_lat);
    int lat, bcnt;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sg;
    sb8.push_back('{q: 32'(eq), r: 32'(er), dbz: ez, ovf: eo});
    @(posedge clk); #1 start8 = 1'b0;
    chk("dut8_accept_clear", {q8, r8, dbz8, ovf8}, 0);
    lat = 0; bcnt = 0;
    while (lat < 60) begin
      @(posedge clk); lat++; #1;
      if (busy8) bcnt++;
      if (done8) break;
    end
    chk("dut8_latency", lat, exp_lat);
    chk("dut8_busy_cycles", bcnt, exp_lat - 1);
  endtask

  task automatic opx(input int n, input logic [31:0] a, input logic [31:0] b, input bit sg);
    int    lat;
    bit    dn;
    string nm;
    @(negedge clk);
    if (n == 4) begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sm4 = sg;
      sb4.push_back(model(a, b, 4, sg));
      nm = "dut4_latency";
    end else begin
      start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; sm16 = sg;
      sb16.push_back(model(a, b, 16, sg));
      nm = "dut16_latency";
    end
    @(posedge clk); #1 start4 = 1'b0; start16 = 1'b0;
    lat = 0; dn = 1'b0;
    while (!dn && lat < 60) begin
      @(posedge clk); lat++; #1;
      dn = (n == 4) ? done4 : done16;
    end
    chk(nm, lat, (b == 0) ? LAT_DBZ : lat_norm(n));
  endtask

  initial begin
    int lat, first, second;
    rst = 1'b1;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy8, done8, q8, r8, dbz8, ovf8}, 0);
    rst = 1'b0;

    op8(8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   0, 0, 11);
    op8(8'h9C,  8'd7,   1'b1, 8'hF2,  8'hFE,  0, 0, 11);
    op8(8'd100, 8'hF9,  1'b1, 8'hF2,  8'h02,  0, 0, 11);
    op8(8'h9C,  8'hF9,  1'b1, 8'h0E,  8'hFE,  0, 0, 11);
    op8(8'h9C,  8'd7,   1'b0, 8'h16,  8'h02,  0, 0, 11);
    op8(8'd7,   8'd0,   1'b0, 8'hFF,  8'h07,  1, 0, 2);
    op8(8'd7,   8'd0,   1'b1, 8'hFF,  8'h07,  1, 0, 2);
    op8(8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  0, 1, 11);
    op8(8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  0, 0, 11);
    op8(8'd255, 8'd1,   1'b0, 8'hFF,  8'h00,  0, 0, 11);

    // start held high; operands change mid-flight and are picked up only in IDLE
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd7; sm8 = 1'b0;
    sb8.push_back('{q: 32'd14, r: 32'd2, dbz: 1'b0, ovf: 1'b0});
    sb8.push_back('{q: 32'd16, r: 32'd2, dbz: 1'b0, ovf: 1'b0});
    @(posedge clk); #1 a8 = 8'd50; b8 = 8'd3;
    lat = 0; first = 0; second = 0;
    while (second == 0 && lat < 80) begin
      @(posedge clk); lat++; #1;
      if (done8) begin
        if (first == 0) first = lat;
        else second = lat;
      end
    end
    start8 = 1'b0;
    chk("b2b_first_latency", first, 11);
    chk("b2b_spacing", second - first, 12);

    // reset mid-ITER discards the operation silently
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd9; sm8 = 1'b0;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_iter", {busy8, done8, q8, r8, dbz8, ovf8}, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    op8(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 0, 0, 11);

    for (int sg = 0; sg < 2; sg++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          opx(4, 32'(a), 32'(b), sg[0]);

    opx(16, 32'h8000, 32'hFFFF, 1'b1);
    opx(16, 32'h1234, 32'h0000, 1'b1);
    opx(16, 32'hFFFF, 32'h0001, 1'b0);
    for (int i = 0; i < 800; i++) begin
      logic [31:0] ra, rb;
      ra = 32'($urandom_range(0, 65535));
      rb = 32'($urandom_range(0, 65535));
      opx(16, ra, rb, 1'b0);
      opx(16, ra, rb, 1'b1);
    end

    repeat (3) @(posedge clk);
    chk("scoreboards_drained", sb8.size() + sb4.size() + sb16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
